// File: rtl/psum_store_ctrl_pkg.sv
// psum_store_ctrl_pkg: state encoding and shared constants for the psum store sequencer
package psum_store_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;
  localparam int MODE_W = 2;
endpackage

// File: rtl/psum_store_ctrl_win_counter.sv
// psum_store_ctrl_win_counter: up-counter with sync clear, enable and terminal-count flag
// Ports: clk, rst (async high), clr_i (zero), en_i (increment), last_i (terminal value), tc_o (count == last_i)
module psum_store_ctrl_win_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign tc_o = cnt_q == last_i;
endmodule

// File: rtl/psum_store_ctrl.sv
// psum_store_ctrl: job sequencer gating products into the psum storer and draining its output FIFO
// Ports: start/cfg_* latch a job in IDLE; mult_valid/mult_ack/stall handle products; v/done/acc_in_psum/
// mode/n/in_buf_clear drive the storer; out_buf_valid/dn_ready/out_ren drain output psums; busy/finished report status.
module psum_store_ctrl
  import psum_store_ctrl_pkg::*;
#(
  parameter int N_WIDTH   = 4,
  parameter int WIN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MODE_W-1:0]    cfg_mode,
  input  logic [N_WIDTH-1:0]   cfg_n,
  input  logic [WIN_WIDTH-1:0] cfg_windows,
  input  logic                 mult_valid,
  output logic                 mult_ack,
  input  logic                 stall,
  input  logic                 out_buf_valid,
  input  logic                 dn_ready,
  output logic                 v,
  output logic                 done,
  output logic                 acc_in_psum,
  output logic [MODE_W-1:0]    mode,
  output logic [N_WIDTH-1:0]   n,
  output logic                 in_buf_clear,
  output logic                 out_ren,
  output logic                 busy,
  output logic                 finished
);
  state_t               state_q, state_d;
  logic [MODE_W-1:0]    mode_q;
  logic [N_WIDTH-1:0]   n_q;
  logic [WIN_WIDTH-1:0] win_total_q;
  logic                 acc, prod_tc, win_tc, rd_tc;
  assign acc          = state_q == ST_COMPUTE && mult_valid && !stall;
  assign v            = state_q == ST_COMPUTE && mult_valid;
  assign done         = v && prod_tc;
  assign mult_ack     = acc;
  assign in_buf_clear = state_q == ST_CLEAR;
  assign acc_in_psum  = state_q == ST_FLUSH;
  assign out_ren      = acc_in_psum && out_buf_valid && dn_ready;
  assign busy         = state_q != ST_IDLE;
  assign finished     = state_q == ST_FINISH;
  assign mode         = mode_q;
  assign n            = n_q;
  // prod_cnt wraps to 0 at the end of each window, which is also when win_cnt advances
  psum_store_ctrl_win_counter #(.W(N_WIDTH)) u_prod (
    .clk(clk), .rst(rst), .clr_i(in_buf_clear || (acc && prod_tc)), .en_i(acc),
    .last_i(n_q - 1'b1), .tc_o(prod_tc)
  );
  psum_store_ctrl_win_counter #(.W(WIN_WIDTH)) u_win (
    .clk(clk), .rst(rst), .clr_i(in_buf_clear), .en_i(acc && prod_tc),
    .last_i(win_total_q - 1'b1), .tc_o(win_tc)
  );
  psum_store_ctrl_win_counter #(.W(WIN_WIDTH)) u_rd (
    .clk(clk), .rst(rst), .clr_i(in_buf_clear), .en_i(out_ren),
    .last_i(win_total_q - 1'b1), .tc_o(rd_tc)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = (win_total_q == '0) ? ST_FINISH : ST_COMPUTE;
      ST_COMPUTE: if (acc && prod_tc && win_tc) state_d = ST_SETTLE;
      // one idle cycle lets the storer's registered done retire before the accumulate path switches
      ST_SETTLE:  state_d = ST_FLUSH;
      ST_FLUSH:   if (out_ren && rd_tc) state_d = ST_FINISH;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      n_q         <= '0;
      win_total_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        mode_q      <= cfg_mode;
        n_q         <= (cfg_n == '0) ? N_WIDTH'(1) : cfg_n;
        win_total_q <= cfg_windows;
      end
    end
endmodule

// File: tb/tb_psum_store_ctrl.sv
// tb_psum_store_ctrl: scoreboard bench for the psum store sequencer
module tb_psum_store_ctrl;
  logic       clk, rst, start, mult_valid, stall, out_buf_valid, dn_ready;
  logic [1:0] cfg_mode, mode;
  logic [3:0] cfg_n, n;
  logic [7:0] cfg_windows;
  logic       mult_ack, v, done, acc_in_psum, in_buf_clear, out_ren, busy, finished;
  int n_chk, n_pass, cyc, ack_cnt, ren_cnt, v_cyc, fin_cnt, fin_cyc;
  bit exp_q[$];
  psum_store_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_n(cfg_n),
    .cfg_windows(cfg_windows), .mult_valid(mult_valid), .mult_ack(mult_ack), .stall(stall),
    .out_buf_valid(out_buf_valid), .dn_ready(dn_ready), .v(v), .done(done),
    .acc_in_psum(acc_in_psum), .mode(mode), .n(n), .in_buf_clear(in_buf_clear),
    .out_ren(out_ren), .busy(busy), .finished(finished)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic sample();
    if (mult_ack) begin
      ack_cnt++;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("done", done, exp_q.pop_front());
    end
    if (v) v_cyc++;
    if (out_ren) begin
      ren_cnt++;
      check("ren_gate", {out_buf_valid, dn_ready}, 2'b11);
    end
    if (finished) begin
      fin_cnt++;
      fin_cyc = cyc;
      check("fin_psum", acc_in_psum, 0);
    end
  endtask
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic run_job(input logic [1:0] cm, input logic [3:0] cn, input logic [7:0] cw,
                         input bit stall_en, input bit flush_pat, input int exp_v, input int exp_lat);
    int nn, a0, r0, v0, f0, s, c;
    nn = (cn == 0) ? 1 : int'(cn);
    for (int k = 0; k < nn * int'(cw); k++) exp_q.push_back((k % nn) == nn - 1);
    a0 = ack_cnt; r0 = ren_cnt; v0 = v_cyc; f0 = fin_cnt;
    cfg_mode = cm; cfg_n = cn; cfg_windows = cw;
    start = 1; mult_valid = 1; stall = 0; out_buf_valid = 1; dn_ready = 1;
    s = cyc;
    step();
    start = 0;
    check("clear", {busy, in_buf_clear}, 2'b11);
    check("n_out", n, nn);
    check("mode_out", mode, cm);
    step();
    c = 0;
    while (fin_cnt == f0 && c < 300) begin
      stall = stall_en && c[0];
      if (flush_pat) begin
        out_buf_valid = !(c >= 7 && c <= 9);
        dn_ready = c[0];
        start = c == 2;
        cfg_n = 4'd7; cfg_windows = 8'd9; cfg_mode = ~cm;
      end
      step();
      c++;
    end
    if (c >= 300) check("timeout", c, 0);
    start = 0; mult_valid = 0; stall = 0;
    check("acks", ack_cnt - a0, nn * int'(cw));
    check("rens", ren_cnt - r0, cw);
    check("v_cycles", v_cyc - v0, exp_v);
    check("latency", fin_cyc - s, exp_lat);
    check("busy_fall", busy, 0);
    check("n_hold", n, nn);
    check("sb_empty", exp_q.size(), 0);
  endtask
  initial begin
    int a0;
    rst = 1; start = 0; cfg_mode = 0; cfg_n = 0; cfg_windows = 0;
    mult_valid = 0; stall = 0; out_buf_valid = 0; dn_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {mult_ack, v, done, acc_in_psum, mode, n, in_buf_clear, out_ren, busy, finished}, 0);
    rst = 0;
    step();
    run_job(2'd1, 4'd3, 8'd2, 0, 0, 6, 11);
    run_job(2'd2, 4'd3, 8'd2, 1, 0, 11, 16);
    run_job(2'd3, 4'd3, 8'd0, 0, 0, 0, 2);
    run_job(2'd0, 4'd0, 8'd1, 0, 0, 1, 5);
    run_job(2'd1, 4'd2, 8'd3, 0, 1, 6, 18);
    a0 = ack_cnt;
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 3) == 2);
    cfg_mode = 2'd3; cfg_n = 4'd3; cfg_windows = 8'd2;
    start = 1; mult_valid = 1; stall = 0;
    step();
    start = 0;
    repeat (3) step();
    rst = 1;
    #1;
    check("rst_outs", {mult_ack, v, done, acc_in_psum, mode, n, in_buf_clear, out_ren, busy, finished}, 0);
    check("rst_acks", ack_cnt - a0, 2);
    exp_q.delete();
    #1;
    rst = 0; mult_valid = 0;
    step();
    run_job(2'd2, 4'd3, 8'd2, 0, 0, 6, 11);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
